pipe_ex_stage: RTL

PIPE_EX_STAGE -- requirements
Module: pipe_ex_stage

---
 rtl/pipe_ex_stage_if.sv | 39 +++
 rtl/pipe_ex_stage.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/pipe_ex_stage_if.sv
// ID->EX control/operand bundle and EX->MEM result bundle for the execute stage.
// The master side is the decode stage / MEM consumer; the slave side is pipe_ex_stage.
interface pipe_ex_stage_if;
    logic        IDwreg;
    logic        IDm2reg;
    logic        IDwmem;
    logic        IDisStoreHazards;
    logic        IDshift;
    logic        IDaluimm;
    logic        IDjal;
    logic        IDmul;
    logic [3:0]  IDaluc;
    logic [4:0]  IDwn;
    logic [31:0] IDqa;
    logic [31:0] IDqb;
    logic [31:0] IDimm;
    logic [31:0] IDpc4;

    logic        EXwreg;
    logic        EXm2reg;
    logic        EXwmem;
    logic        EXisStoreHazards;
    logic [4:0]  EXwn;
    logic [31:0] EXaluResult;
    logic [31:0] EXqb;
    logic        EXbusy;

    modport master (
        output IDwreg, IDm2reg, IDwmem, IDisStoreHazards, IDshift, IDaluimm, IDjal, IDmul,
        output IDaluc, IDwn, IDqa, IDqb, IDimm, IDpc4,
        input  EXwreg, EXm2reg, EXwmem, EXisStoreHazards, EXwn, EXaluResult, EXqb, EXbusy
    );

    modport slave (
        input  IDwreg, IDm2reg, IDwmem, IDisStoreHazards, IDshift, IDaluimm, IDjal, IDmul,
        input  IDaluc, IDwn, IDqa, IDqb, IDimm, IDpc4,
        output EXwreg, EXm2reg, EXwmem, EXisStoreHazards, EXwn, EXaluResult, EXqb, EXbusy
    );
endinterface

// File: rtl/pipe_ex_stage.sv
// Execute stage: ID/EX register, combinational ALU, optional 32-cycle shift-add multiplier.
// Define EX_MULT_EN to build the multiplier; otherwise IDmul is ignored and EXbusy is 0.
module pipe_ex_stage (
    input  logic          clk,
    input  logic          clrn,
    pipe_ex_stage_if.slave ex
);

    logic        wreg_reg;
    logic        m2reg_reg;
    logic        wmem_reg;
    logic        store_haz_reg;
    logic        shift_reg;
    logic        aluimm_reg;
    logic        jal_reg;
    logic [3:0]  aluc_reg;
    logic [4:0]  wn_reg;
    logic [31:0] qa_reg;
    logic [31:0] qb_reg;
    logic [31:0] imm_reg;
    logic [31:0] pc4_reg;

    logic        busy;
    logic        mul_done;
    logic [31:0] mul_result;

    always_ff @(posedge clk) begin
        if (!clrn) begin
            wreg_reg      <= 1'b0;
            m2reg_reg     <= 1'b0;
            wmem_reg      <= 1'b0;
            store_haz_reg <= 1'b0;
            shift_reg     <= 1'b0;
            aluimm_reg    <= 1'b0;
            jal_reg       <= 1'b0;
            aluc_reg      <= 4'd0;
            wn_reg        <= 5'd0;
            qa_reg        <= 32'd0;
            qb_reg        <= 32'd0;
            imm_reg       <= 32'd0;
            pc4_reg       <= 32'd0;
        end else if (!busy) begin
            wreg_reg      <= ex.IDwreg;
            m2reg_reg     <= ex.IDm2reg;
            wmem_reg      <= ex.IDwmem;
            store_haz_reg <= ex.IDisStoreHazards;
            shift_reg     <= ex.IDshift;
            aluimm_reg    <= ex.IDaluimm;
            jal_reg       <= ex.IDjal;
            aluc_reg      <= ex.IDaluc;
            wn_reg        <= ex.IDwn;
            qa_reg        <= ex.IDqa;
            qb_reg        <= ex.IDqb;
            imm_reg       <= ex.IDimm;
            pc4_reg       <= ex.IDpc4;
        end
    end

`ifdef EX_MULT_EN
    typedef enum logic [1:0] {IDLE, MUL, DONE} mul_state_t;

    mul_state_t  state_reg, state_next;
    logic [31:0] mcand_reg, mcand_next;
    logic [31:0] mplier_reg, mplier_next;
    logic [31:0] product_reg, product_next;
    logic [4:0]  count_reg, count_next;

    always_ff @(posedge clk) begin
        if (!clrn) begin
            state_reg   <= IDLE;
            mcand_reg   <= 32'd0;
            mplier_reg  <= 32'd0;
            product_reg <= 32'd0;
            count_reg   <= 5'd0;
        end else begin
            state_reg   <= state_next;
            mcand_reg   <= mcand_next;
            mplier_reg  <= mplier_next;
            product_reg <= product_next;
            count_reg   <= count_next;
        end
    end

    // A new instruction is captured in both IDLE and DONE, so a multiply can start from either.
    always_comb begin
        state_next   = state_reg;
        mcand_next   = mcand_reg;
        mplier_next  = mplier_reg;
        product_next = product_reg;
        count_next   = count_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (ex.IDmul) begin
                    state_next   = MUL;
                    mcand_next   = ex.IDqa;
                    mplier_next  = ex.IDqb;
                    product_next = 32'd0;
                    count_next   = 5'd0;
                end else begin
                    state_next = IDLE;
                end
            end
            MUL: begin
                if (mplier_reg[0]) begin
                    product_next = product_reg + mcand_reg;
                end
                mcand_next  = mcand_reg << 1;
                mplier_next = mplier_reg >> 1;
                count_next  = count_reg + 5'd1;
                if (count_reg == 5'd31) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy       = (state_reg == MUL);
    assign mul_done   = (state_reg == DONE);
    assign mul_result = product_reg;
`else
    logic unused_mul;

    assign unused_mul = ex.IDmul;
    assign busy       = 1'b0;
    assign mul_done   = 1'b0;
    assign mul_result = 32'd0;
`endif

    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] alu_result;

    assign op_a = shift_reg  ? {27'd0, imm_reg[10:6]} : qa_reg;
    assign op_b = aluimm_reg ? imm_reg : qb_reg;

    always_comb begin
        alu_result = 32'd0;
        case (aluc_reg)
            4'b0000: alu_result = op_a + op_b;
            4'b0001: alu_result = op_a - op_b;
            4'b0010: alu_result = op_a & op_b;
            4'b0011: alu_result = op_a | op_b;
            4'b0100: alu_result = op_a ^ op_b;
            4'b0101: alu_result = op_b << 16;
            4'b0110: alu_result = op_b << op_a[4:0];
            4'b0111: alu_result = op_b >> op_a[4:0];
            4'b1000: alu_result = $unsigned($signed(op_b) >>> op_a[4:0]);
            4'b1001: alu_result = {31'd0, $signed(op_a) < $signed(op_b)};
            default: alu_result = 32'd0;
        endcase
    end

    // While multiplying, MEM must see a bubble: no register or memory write.
    assign ex.EXwreg           = wreg_reg & ~busy;
    assign ex.EXwmem           = wmem_reg & ~busy;
    assign ex.EXm2reg          = m2reg_reg;
    assign ex.EXisStoreHazards = store_haz_reg;
    assign ex.EXwn             = wn_reg;
    assign ex.EXqb             = qb_reg;
    assign ex.EXbusy           = busy;
    assign ex.EXaluResult      = jal_reg  ? pc4_reg :
                                 mul_done ? mul_result : alu_result;

endmodule
